// File: rtl/id_scoreboard.sv
// Decode/issue stage with a per-register pending-writer scoreboard and source operand selection.
// Define ID_SB_FWD_EN to enable bypass selection from the fwd_* sources; otherwise pending sources wait for retire.
module id_scoreboard #(
  parameter int FWD_STAGES   = 3,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_allow,
  input  logic [31:0]             in_pc,
  input  logic                    in_src1_en,
  input  logic                    in_src2_en,
  input  logic [4:0]              in_src1,
  input  logic [4:0]              in_src2,
  input  logic                    in_dst_we,
  input  logic [4:0]              in_dst,
  output logic                    out_valid,
  input  logic                    out_allow,
  output logic [31:0]             out_pc,
  output logic [31:0]             out_src1_val,
  output logic [31:0]             out_src2_val,
  output logic                    out_dst_we,
  output logic [4:0]              out_dst,
  output logic [4:0]              rf_raddr1,
  output logic [4:0]              rf_raddr2,
  input  logic [31:0]             rf_rdata1,
  input  logic [31:0]             rf_rdata2,
  input  logic [FWD_STAGES-1:0]   fwd_valid,
  input  logic [FWD_STAGES-1:0]   fwd_ready,
  input  logic [5*FWD_STAGES-1:0] fwd_dest,
  input  logic [32*FWD_STAGES-1:0] fwd_data,
  input  logic                    ret_valid,
  input  logic [4:0]              ret_dest,
  input  logic                    ret_we,
  input  logic [31:0]             ret_data,
  input  logic                    flush,
  output logic                    sb_err
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

  logic          id_valid_q, id_valid_d;
  logic [31:0]   pc_q;
  logic          src1_en_q, src2_en_q;
  logic [4:0]    src1_q, src2_q;
  logic          dst_we_q;
  logic [4:0]    dst_q;
  logic [CW-1:0] cnt_q [32];
  logic [CW-1:0] cnt_d [32];
  logic          err_q, err_d;

  logic          src1_stall, src2_stall, sat_stall, ready_go;
  logic [31:0]   src1_val, src2_val;
  logic          load, issue, inc, dec;

  // Returns {stall, value}; a retiring last writer wins over the bypass network.
  function automatic logic [32:0] resolve(input logic en, input logic [4:0] src,
                                          input logic [CW-1:0] cnt, input logic [31:0] rdata);
    logic [31:0] val;
    logic        stall;
    val   = '0;
    stall = 1'b0;
    if (src != 5'd0) begin
      if (!en || cnt == '0) begin
        val = rdata;
      end else if (ret_valid && ret_we && ret_dest == src && cnt == CW'(1)) begin
        val = ret_data;
      end else begin
        stall = 1'b1;
`ifdef ID_SB_FWD_EN
        // Walk oldest to youngest so the lowest matching index is the one that sticks.
        for (int i = FWD_STAGES - 1; i >= 0; i--) begin
          if (fwd_valid[i] && fwd_dest[5*i +: 5] == src) begin
            stall = !fwd_ready[i];
            val   = fwd_data[32*i +: 32];
          end
        end
`endif
      end
    end
    return {stall, val};
  endfunction

`ifndef ID_SB_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{fwd_valid, fwd_ready, fwd_dest, fwd_data};
`endif

  always_comb begin
    {src1_stall, src1_val} = resolve(src1_en_q, src1_q, cnt_q[src1_q], rf_rdata1);
    {src2_stall, src2_val} = resolve(src2_en_q, src2_q, cnt_q[src2_q], rf_rdata2);
  end

  assign sat_stall = dst_we_q && dst_q != 5'd0 && cnt_q[dst_q] == CNT_MAX;
  assign ready_go  = id_valid_q && !src1_stall && !src2_stall && !sat_stall;
  assign in_allow  = !id_valid_q || (ready_go && out_allow);
  assign out_valid = id_valid_q && ready_go;

  // A flushed entry never counts as issued, even if EX accepts it this cycle.
  assign issue = out_valid && out_allow && !flush;
  assign load  = in_valid && in_allow && !flush;
  assign inc   = issue && dst_we_q && dst_q != 5'd0;
  assign dec   = ret_valid && ret_dest != 5'd0;

  assign out_pc       = pc_q;
  assign out_src1_val = src1_val;
  assign out_src2_val = src2_val;
  assign out_dst_we   = dst_we_q;
  assign out_dst      = dst_q;
  assign rf_raddr1    = src1_q;
  assign rf_raddr2    = src2_q;
  assign sb_err       = err_q;

  always_comb begin
    if (flush)      id_valid_d = 1'b0;
    else if (load)  id_valid_d = 1'b1;
    else if (issue) id_valid_d = 1'b0;
    else            id_valid_d = id_valid_q;
  end

  always_comb begin
    cnt_d    = cnt_q;
    cnt_d[0] = '0;
    err_d    = err_q;
    for (int r = 1; r < 32; r++) begin
      if (inc && dst_q == 5'(r) && !(dec && ret_dest == 5'(r))) begin
        cnt_d[r] = cnt_q[r] + CW'(1);
      end else if (dec && ret_dest == 5'(r) && !(inc && dst_q == 5'(r))) begin
        if (cnt_q[r] == '0) err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid_q <= 1'b0;
      pc_q       <= '0;
      src1_en_q  <= 1'b0;
      src2_en_q  <= 1'b0;
      src1_q     <= '0;
      src2_q     <= '0;
      dst_we_q   <= 1'b0;
      dst_q      <= '0;
      err_q      <= 1'b0;
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      id_valid_q <= id_valid_d;
      err_q      <= err_d;
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
      if (load) begin
        pc_q      <= in_pc;
        src1_en_q <= in_src1_en;
        src2_en_q <= in_src2_en;
        src1_q    <= in_src1;
        src2_q    <= in_src2;
        dst_we_q  <= in_dst_we;
        dst_q     <= in_dst;
      end
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Scoreboard bench for id_scoreboard: expected issues are queued at load time and compared on issue.
// Expectations follow ID_SB_FWD_EN when the same macro is defined for the bench.
module tb_id_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_allow;
  logic [31:0] in_pc;
  logic        in_src1_en, in_src2_en;
  logic [4:0]  in_src1, in_src2;
  logic        in_dst_we;
  logic [4:0]  in_dst;
  logic        out_valid, out_allow;
  logic [31:0] out_pc, out_src1_val, out_src2_val;
  logic        out_dst_we;
  logic [4:0]  out_dst;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [2:0]  fwd_valid, fwd_ready;
  logic [14:0] fwd_dest;
  logic [95:0] fwd_data;
  logic        ret_valid, ret_we;
  logic [4:0]  ret_dest;
  logic [31:0] ret_data;
  logic        flush, sb_err;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] v1;
    logic [31:0] v2;
    logic        we;
    logic [4:0]  dst;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] rf [32];
  int          n_chk  = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  id_scoreboard #(.FWD_STAGES(3), .MAX_INFLIGHT(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_allow(in_allow), .in_pc(in_pc),
    .in_src1_en(in_src1_en), .in_src2_en(in_src2_en), .in_src1(in_src1), .in_src2(in_src2),
    .in_dst_we(in_dst_we), .in_dst(in_dst),
    .out_valid(out_valid), .out_allow(out_allow), .out_pc(out_pc),
    .out_src1_val(out_src1_val), .out_src2_val(out_src2_val),
    .out_dst_we(out_dst_we), .out_dst(out_dst),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .ret_valid(ret_valid), .ret_dest(ret_dest), .ret_we(ret_we), .ret_data(ret_data),
    .flush(flush), .sb_err(sb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Issue monitor: every accepted transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_allow) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue_pc", out_pc, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue_pc", out_pc, mon_e.pc);
        check("issue_src1", out_src1_val, mon_e.v1);
        check("issue_src2", out_src2_val, mon_e.v2);
        check("issue_dst", {26'd0, out_dst_we, out_dst}, {26'd0, mon_e.we, mon_e.dst});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic s1en, input logic [4:0] s1,
                      input logic s2en, input logic [4:0] s2, input logic we, input logic [4:0] dst,
                      input logic [31:0] e1, input logic [31:0] e2, input bit push);
    exp_t e;
    int   n;
    in_valid = 1'b1; in_pc = pc;
    in_src1_en = s1en; in_src1 = s1; in_src2_en = s2en; in_src2 = s2;
    in_dst_we = we; in_dst = dst;
    if (push) begin
      e.pc = pc; e.v1 = e1; e.v2 = e2; e.we = we; e.dst = dst;
      exp_q.push_back(e);
    end
    n = 0;
    @(negedge clk);
    while (!in_allow && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_allow) check("send_timeout", 32'(in_allow), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_src1_en = 1'b0; in_src2_en = 1'b0; in_dst_we = 1'b0;
  endtask

  task automatic set_fwd(input int st, input logic v, input logic [4:0] d, input logic rdy,
                         input logic [31:0] dat);
    fwd_valid[st] = v;
    fwd_ready[st] = rdy;
    fwd_dest[5*st +: 5]   = d;
    fwd_data[32*st +: 32] = dat;
  endtask

  task automatic clr_fwd();
    fwd_valid = '0; fwd_ready = '0; fwd_dest = '0; fwd_data = '0;
  endtask

  task automatic retire(input logic [4:0] d, input logic we, input logic [31:0] dat);
    ret_valid = 1'b1; ret_dest = d; ret_we = we; ret_data = dat;
    tick();
    ret_valid = 1'b0; ret_we = 1'b0; ret_dest = '0; ret_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : 32'hA000_0000 + 32'(i);
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_src1_en = 1'b0; in_src2_en = 1'b0;
    in_src1 = '0; in_src2 = '0; in_dst_we = 1'b0; in_dst = '0; out_allow = 1'b1;
    ret_valid = 1'b0; ret_dest = '0; ret_we = 1'b0; ret_data = '0; flush = 1'b0;
    clr_fwd();
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_allow", 32'(in_allow), 32'd1);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_src1_val", out_src1_val, 32'd0);
    check("rst_src2_val", out_src2_val, 32'd0);
    check("rst_dst", {26'd0, out_dst_we, out_dst}, 32'd0);
    check("rst_sb_err", 32'(sb_err), 32'd0);
    tick();

    // Writer r5 then consumer of r5 with a ready bypass at stage 0.
    send(32'h100, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'd0, 32'd0, 1'b1);
    set_fwd(0, 1'b1, 5'd5, 1'b1, 32'h1234);
`ifdef ID_SB_FWD_EN
    send(32'h104, 1'b1, 5'd5, 1'b1, 5'd1, 1'b0, 5'd0, 32'h1234, rf[1], 1'b1);
    tick();
    clr_fwd();
    retire(5'd5, 1'b1, 32'h0);
`else
    send(32'h104, 1'b1, 5'd5, 1'b1, 5'd1, 1'b0, 5'd0, 32'hBEEF, rf[1], 1'b1);
    @(negedge clk);
    check("nofwd_stall_a", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    check("nofwd_stall_b", 32'(out_valid), 32'd0);
    tick();
    clr_fwd();
    retire(5'd5, 1'b1, 32'hBEEF);
`endif

    // Load to r7 not ready at stage 0, then ready at stage 1.
    send(32'h200, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'd0, 32'd0, 1'b1);
    set_fwd(0, 1'b1, 5'd7, 1'b0, 32'hDEAD);
    send(32'h204, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 32'hAA, 32'd0, 1'b1);
    @(negedge clk);
    check("load_stall_valid", 32'(out_valid), 32'd0);
    check("load_stall_allow", 32'(in_allow), 32'd0);
    tick();
    clr_fwd();
    set_fwd(1, 1'b1, 5'd7, 1'b1, 32'hAA);
`ifdef ID_SB_FWD_EN
    tick();
    clr_fwd();
    retire(5'd7, 1'b1, 32'h0);
`else
    @(negedge clk);
    check("load_nofwd_stall", 32'(out_valid), 32'd0);
    tick();
    clr_fwd();
    retire(5'd7, 1'b1, 32'hAA);
`endif

    // Four in-flight writers to r3 saturate the counter.
    for (int k = 0; k < 4; k++)
      send(32'h300 + 32'(4 * k), 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'd0, 32'd0, 1'b1);
    send(32'h310, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    check("sat_stall_valid", 32'(out_valid), 32'd0);
    check("sat_stall_allow", 32'(in_allow), 32'd0);
    tick();
    @(negedge clk);
    check("sat_stall_hold", 32'(out_valid), 32'd0);
    tick();
    ret_valid = 1'b1; ret_dest = 5'd3; ret_we = 1'b1; ret_data = 32'h0;
    @(negedge clk);
    check("sat_ret_cycle", 32'(out_valid), 32'd0);
    tick();
    ret_valid = 1'b0; ret_we = 1'b0; ret_dest = '0;
    @(negedge clk);
    check("sat_release", 32'(out_valid), 32'd1);
    tick();
    repeat (4) retire(5'd3, 1'b1, 32'h0);

    // Retire of the last writer to r9 in the same cycle as its reader.
    send(32'h400, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'd0, 32'd0, 1'b1);
    send(32'h404, 1'b1, 5'd1, 1'b1, 5'd9, 1'b0, 5'd0, rf[1], 32'h55, 1'b1);
    retire(5'd9, 1'b1, 32'h55);
    send(32'h408, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, rf[9], 32'd0, 1'b1);
    tick();

    // Flush a stalled entry that writes r4, then flush over a load.
    send(32'h500, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6, 32'd0, 32'd0, 1'b1);
    send(32'h504, 1'b1, 5'd6, 1'b0, 5'd0, 1'b1, 5'd4, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("pre_flush_stall", 32'(out_valid), 32'd0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_kill_valid", 32'(out_valid), 32'd0);
    check("flush_kill_allow", 32'(in_allow), 32'd1);
    tick();
    flush = 1'b1;
    send(32'h508, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 32'd0, 32'd0, 1'b0);
    flush = 1'b0;
    @(negedge clk);
    check("flush_over_load", 32'(out_valid), 32'd0);
    tick();
    send(32'h50C, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, rf[4], 32'd0, 1'b1);
    out_allow = 1'b0;
    @(negedge clk);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_in_allow", 32'(in_allow), 32'd0);
    tick();
    out_allow = 1'b1;
    tick();
    retire(5'd6, 1'b1, 32'h0);
    @(negedge clk);
    check("err_clear", 32'(sb_err), 32'd0);
    tick();
    retire(5'd10, 1'b1, 32'h0);
    @(negedge clk);
    check("err_set", 32'(sb_err), 32'd1);
    repeat (3) tick();
    @(negedge clk);
    check("err_sticky", 32'(sb_err), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("err_after_reset", 32'(sb_err), 32'd0);
    check("reset2_in_allow", 32'(in_allow), 32'd1);
    check("reset2_out_valid", 32'(out_valid), 32'd0);
    tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
